irq_controller: RTL and testbench

- Memory-mapped external interrupt controller feeding the CP0 external IRQ inputs `interrupts[7:4]`, which map to Cause.IP[7:4].
- Collects N peripheral interrupt sources and latches them as level or rising-edge.
- Masks each source, routes it to one of four CPU lines, and offers a CLAIM register so software can identify and acknowledge the lowest-numbered active source.
- Sits on the data bus beside the other MMIO peripherals; software drives it from the exception handler.

---
 rtl/irq_controller_pkg.sv | 27 ++
 rtl/irq_controller_if.sv | 11 +
 rtl/irq_controller_source.sv | 44 ++++
 rtl/irq_controller.sv | 103 ++++++++++
 tb/tb_irq_controller.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants for the external interrupt controller: register indices,
// CLAIM word layout and MODE encodings.
package irqc_pkg;

  localparam logic [2:0] IRQC_PENDING = 3'd0;
  localparam logic [2:0] IRQC_ENABLE  = 3'd1;
  localparam logic [2:0] IRQC_MODE    = 3'd2;
  localparam logic [2:0] IRQC_ROUTE   = 3'd3;
  localparam logic [2:0] IRQC_CLAIM   = 3'd4;
  localparam logic [2:0] IRQC_RAW     = 3'd5;

  localparam int IRQC_CLAIM_VLD = 31;

  localparam logic IRQC_LEVEL = 1'b0;
  localparam logic IRQC_EDGE  = 1'b1;

  function automatic logic [31:0] claim_word(input logic vld, input logic [4:0] id);
    logic [31:0] w;
    w = '0;
    if (vld) begin
      w[IRQC_CLAIM_VLD] = 1'b1;
      w[4:0]            = id;
    end
    return w;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Register bus between the CPU data path and the interrupt controller.
interface irq_controller_if;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/irq_controller_source.sv
// One interrupt source: optional 2-flop synchronizer (IRQC_SYNC_EN), edge
// history and the pending bit in level or rising-edge mode.
module irqc_source
  import irqc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic clr,
  input  logic mode_chg,
  output logic s,
  output logic pending
);

`ifdef IRQC_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], src};
  end
  assign s = sync[1];
`else
  assign s = src;
`endif

  logic prev;

  // A rising edge beats a simultaneous clear; a mode change wipes the bit and
  // resyncs history so the new mode starts without a phantom edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= s;
      if (mode_chg)                pending <= 1'b0;
      else if (mode == IRQC_LEVEL) pending <= s;
      else if (s && !prev)         pending <= 1'b1;
      else if (clr)                pending <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped external interrupt controller driving CP0 interrupts[7:4].
// Build option: define IRQC_SYNC_EN to put a 2-flop synchronizer on each src.
module irq_controller
  import irqc_pkg::*;
#(
  parameter int NSRC   = 16,
  parameter int NLINES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC-1:0]     src,
  irq_controller_if.slave     bus,
  output logic [NLINES-1:0]   irq_out
);

  logic [NSRC-1:0]   enable, mode, pending, raw, active, clr, mode_chg, claim_oh;
  logic [2*NSRC-1:0] route;
  logic [NLINES-1:0] line_nxt;
  logic [4:0]        claim_id;
  logic              claim_vld, wr, rd, claim_rd;

  assign wr       = bus.sel & bus.we;
  assign rd       = bus.sel & ~bus.we;
  assign active   = pending & enable;
  assign claim_rd = rd && (bus.addr == IRQC_CLAIM) && claim_vld;

  // Lowest-numbered enabled pending source wins; routing is irrelevant here.
  always_comb begin
    claim_vld = 1'b0;
    claim_id  = '0;
    claim_oh  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_vld   = 1'b1;
        claim_id    = 5'(i);
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (wr && bus.addr == IRQC_PENDING) clr = bus.wdata[NSRC-1:0];
    if (claim_rd)                       clr = clr | claim_oh;
  end

  assign mode_chg = (wr && bus.addr == IRQC_MODE) ? (bus.wdata[NSRC-1:0] ^ mode) : '0;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irqc_source u_src (
      .clk      (clk),
      .reset    (reset),
      .src      (src[g]),
      .mode     (mode[g]),
      .clr      (clr[g]),
      .mode_chg (mode_chg[g]),
      .s        (raw[g]),
      .pending  (pending[g])
    );
  end

  always_comb begin
    line_nxt = '0;
    for (int i = 0; i < NSRC; i++)
      if (active[i]) line_nxt[route[2*i +: 2]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable  <= '0;
      mode    <= '0;
      route   <= '0;
      irq_out <= '0;
    end else begin
      if (wr) begin
        case (bus.addr)
          IRQC_ENABLE: enable <= bus.wdata[NSRC-1:0];
          IRQC_MODE:   mode   <= bus.wdata[NSRC-1:0];
          IRQC_ROUTE:  route  <= bus.wdata[2*NSRC-1:0];
          default: ;
        endcase
      end
      irq_out <= line_nxt;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr)
        IRQC_PENDING: bus.rdata = 32'(pending);
        IRQC_ENABLE:  bus.rdata = 32'(enable);
        IRQC_MODE:    bus.rdata = 32'(mode);
        IRQC_ROUTE:   bus.rdata = 32'(route);
        IRQC_CLAIM:   bus.rdata = claim_word(claim_vld, claim_id);
        IRQC_RAW:     bus.rdata = 32'(raw);
        default:      bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_irq_controller;
  import irqc_pkg::*;

`ifdef IRQC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] src;
  logic [3:0]  irq_out;

  irq_controller_if bus();

  irq_controller #(.NSRC(16), .NLINES(4)) dut (
    .clk(clk), .reset(reset), .src(src), .bus(bus), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit [15:0] m_pend, m_en, m_mode, m_prev, m_s1, m_s2;
  bit [31:0] m_route;
  bit [3:0]  m_irq;

  function automatic bit [15:0] m_s();
    return (SYNC != 0) ? m_s2 : src;
  endfunction

  function automatic bit [31:0] m_claim();
    for (int i = 0; i < 16; i++)
      if (m_pend[i] && m_en[i]) return 32'h8000_0000 + i;
    return 32'h0;
  endfunction

  function automatic bit [31:0] m_read(bit [2:0] a);
    case (a)
      3'd0: return {16'h0, m_pend};
      3'd1: return {16'h0, m_en};
      3'd2: return {16'h0, m_mode};
      3'd3: return m_route;
      3'd4: return m_claim();
      3'd5: return {16'h0, m_s()};
      default: return 32'h0;
    endcase
  endfunction

  // Advance one clock: evaluate the rules on current inputs, then commit.
  task automatic step();
    bit [15:0] s, np;
    bit [3:0]  ni;
    bit [31:0] cl;
    bit        wr, rd, chg, clr;
    s  = m_s();
    wr = bus.sel && bus.we;
    rd = bus.sel && !bus.we;
    cl = m_claim();
    for (int i = 0; i < 16; i++) begin
      chg = wr && bus.addr == 3'd2 && (bus.wdata[i] != m_mode[i]);
      clr = (wr && bus.addr == 3'd0 && bus.wdata[i]) ||
            (rd && bus.addr == 3'd4 && cl[31] && cl[4:0] == i);
      if (chg)             np[i] = 1'b0;
      else if (!m_mode[i]) np[i] = s[i];
      else if (s[i] && !m_prev[i]) np[i] = 1'b1;
      else if (clr)        np[i] = 1'b0;
      else                 np[i] = m_pend[i];
    end
    ni = '0;
    for (int i = 0; i < 16; i++)
      if (m_pend[i] && m_en[i]) ni[m_route[2*i +: 2]] = 1'b1;
    @(posedge clk);
    #1;
    if (reset) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_route = '0;
      m_prev = '0; m_s1 = '0; m_s2 = '0; m_irq = '0;
    end else begin
      m_prev = s;
      m_s2   = m_s1;
      m_s1   = src;
      m_pend = np;
      m_irq  = ni;
      if (wr && bus.addr == 3'd1) m_en    = bus.wdata[15:0];
      if (wr && bus.addr == 3'd2) m_mode  = bus.wdata[15:0];
      if (wr && bus.addr == 3'd3) m_route = bus.wdata;
    end
  endtask

  task automatic settle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus_wr(bit [2:0] a, bit [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    step();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_rd(bit [2:0] a, output logic [31:0] got);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    got = bus.rdata;
    step();
    bus.sel = 1'b0;
  endtask

  task automatic do_reset();
    src   = '0;
    reset = 1'b1;
    settle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      bus_rd(3'(a), v);
      n_tests++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got=%h exp=%h", a, v, 32'h0);
      end
    end
    n_tests++;
    if (irq_out !== 4'b0) begin
      n_fail++; $display("FAIL reset_irq got=%b exp=0000", irq_out);
    end
  endtask

  task automatic test_edge();
    logic [31:0] v;
    do_reset();
    bus_wr(3'd1, 32'h1);
    bus_wr(3'd2, 32'h1);
    bus_wr(3'd3, 32'h0);
    src[0] = 1'b1;
    step();
    src[0] = 1'b0;
    settle(SYNC);
    n_tests++;
    if (irq_out !== 4'b0000) begin
      n_fail++; $display("FAIL edge_irq_early got=%b exp=0000", irq_out);
    end
    step();
    n_tests++;
    if (irq_out !== 4'b0001) begin
      n_fail++; $display("FAIL edge_irq got=%b exp=0001", irq_out);
    end
    bus_rd(3'd0, v);
    n_tests++;
    if (v !== 32'h1) begin
      n_fail++; $display("FAIL edge_pending got=%h exp=%h", v, 32'h1);
    end
    bus_wr(3'd0, 32'h1);
    step();
    n_tests++;
    if (irq_out !== 4'b0000) begin
      n_fail++; $display("FAIL edge_w1c_irq got=%b exp=0000", irq_out);
    end
  endtask

  task automatic test_level();
    logic [31:0] v;
    do_reset();
    src[3] = 1'b1;
    bus_wr(3'd1, 32'h8);
    bus_wr(3'd3, 32'h80);
    settle(SYNC + 1);
    n_tests++;
    if (irq_out !== 4'b0100) begin
      n_fail++; $display("FAIL level_irq got=%b exp=0100", irq_out);
    end
    bus_wr(3'd0, 32'h8);
    bus_rd(3'd0, v);
    n_tests++;
    if (v !== 32'h8 || irq_out !== 4'b0100) begin
      n_fail++; $display("FAIL level_w1c pend=%h irq=%b exp pend=8 irq=0100", v, irq_out);
    end
    src[3] = 1'b0;
    settle(SYNC + 1);
    n_tests++;
    if (irq_out !== 4'b0100) begin
      n_fail++; $display("FAIL level_drop_early got=%b exp=0100", irq_out);
    end
    step();
    n_tests++;
    if (irq_out !== 4'b0000) begin
      n_fail++; $display("FAIL level_drop got=%b exp=0000", irq_out);
    end
  endtask

  task automatic test_claim();
    logic [31:0] v;
    do_reset();
    bus_wr(3'd2, 32'h24);
    bus_wr(3'd1, 32'h24);
    src = 16'h0024;
    step();
    src = '0;
    settle(SYNC + 1);
    n_tests++;
    if (irq_out !== 4'b0001) begin
      n_fail++; $display("FAIL claim_irq_before got=%b exp=0001", irq_out);
    end
    bus_rd(3'd4, v);
    n_tests++;
    if (v !== 32'h8000_0002) begin
      n_fail++; $display("FAIL claim_first got=%h exp=80000002", v);
    end
    bus_rd(3'd4, v);
    n_tests++;
    if (v !== 32'h8000_0005) begin
      n_fail++; $display("FAIL claim_second got=%h exp=80000005", v);
    end
    bus_rd(3'd4, v);
    n_tests++;
    if (v !== 32'h0 || irq_out !== 4'b0000) begin
      n_fail++; $display("FAIL claim_empty got=%h irq=%b exp=00000000 irq=0000", v, irq_out);
    end
  endtask

  task automatic test_set_clear_collision();
    logic [31:0] v;
    do_reset();
    bus_wr(3'd2, 32'h2);
    bus_wr(3'd1, 32'h2);
    src[1] = 1'b1;
    settle(SYNC);
    bus_wr(3'd0, 32'h2);
    bus_rd(3'd0, v);
    n_tests++;
    if (v !== 32'h2) begin
      n_fail++; $display("FAIL set_beats_clear got=%h exp=%h", v, 32'h2);
    end
    src[1] = 1'b0;
  endtask

  task automatic test_mode_change();
    logic [31:0] v;
    do_reset();
    src[0] = 1'b1;
    settle(SYNC + 1);
    bus_rd(3'd0, v);
    n_tests++;
    if (v !== 32'h1) begin
      n_fail++; $display("FAIL mode_level_pend got=%h exp=%h", v, 32'h1);
    end
    bus_wr(3'd2, 32'h1);
    bus_rd(3'd0, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL mode_change_clear got=%h exp=%h", v, 32'h0);
    end
    settle(2);
    bus_rd(3'd0, v);
    n_tests++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL mode_no_spurious got=%h exp=%h", v, 32'h0);
    end
    src[0] = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] v, e;
    int op;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(3) == 0) src = 16'($urandom);
      op = $urandom_range(3);
      bus.sel   = (op != 0);
      bus.we    = (op == 1);
      bus.addr  = 3'($urandom_range(7));
      bus.wdata = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      #1;
      if (bus.sel && !bus.we) begin
        v = bus.rdata;
        e = m_read(bus.addr);
        n_tests++;
        if (v !== e) begin
          n_fail++; $display("FAIL rand_read cyc=%0d addr=%0d got=%h exp=%h", n, bus.addr, v, e);
        end
      end
      step();
      n_tests++;
      if (irq_out !== m_irq) begin
        n_fail++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", n, irq_out, m_irq);
      end
    end
    reset   = 1'b0;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src = '0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_edge();
    test_level();
    test_claim();
    test_set_clear_collision();
    test_mode_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
